accel_seq_ctrl: RTL and testbench

//  Programmable, parametrised sequencer that drives all accelerator control enables
//  (weight/input/output buffers, PE weight write, activation) for N back-to-back tiles.

---
 rtl/accel_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_accel_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/accel_seq_ctrl.sv
// Tile sequencer for the systolic accelerator: steps each tile through
// LOAD_W, LOAD_IN, WAIT, CAPTURE and READOUT and drives every buffer/PE/activation enable.
module accel_seq_ctrl #(
    parameter int ARRAY_H   = 8,
    parameter int ARRAY_W   = 8,
    parameter int DSP_DELAY = 1,
    parameter int TILE_W    = 8,
    localparam int ROW_W    = (ARRAY_H > 1) ? $clog2(ARRAY_H) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [1:0]        act_mode,
    output logic              busy,
    output logic              done,
    output logic [TILE_W-1:0] tile_idx,
    output logic [ROW_W-1:0]  row_idx,
    output logic              weight_buffer_load_en,
    output logic              weight_buffer_out_en,
    output logic              write_weight_en,
    output logic              input_buffer_load_en,
    output logic              input_buffer_out_en,
    output logic              output_buffer_load_en,
    output logic              output_buffer_out_en,
    output logic              relu_en,
    output logic              softmax_en
);

    localparam int LEN_LW  = ARRAY_H;
    localparam int LEN_LI  = ARRAY_H;
    localparam int LEN_WT  = DSP_DELAY * ARRAY_W;
    localparam int LEN_CP  = DSP_DELAY * (ARRAY_H - 1) + ARRAY_H;
    localparam int LEN_RO  = ARRAY_H;
    localparam int MAX_LEN = (LEN_CP > LEN_WT) ? LEN_CP : LEN_WT;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_IN, S_WAIT, S_CAPTURE, S_READOUT, S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [TILE_W-1:0] r_tile, w_tile_nxt;
    logic [TILE_W-1:0] r_num, w_num_nxt;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [CNT_W-1:0]  w_last_cnt;
    logic [TILE_W:0]   w_tile_inc;

    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic [TILE_W-1:0] r_tile_o, w_tile_o;
    logic [ROW_W-1:0]  r_row, w_row;
    logic [8:0]        r_en, w_en;

    // State register; outputs are captured here too so every enable leaves a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_tile   <= '0;
            r_num    <= '0;
            r_mode   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tile_o <= '0;
            r_row    <= '0;
            r_en     <= '0;
        end else begin
            // NOTE: non-blocking everywhere in clocked logic so all flops update from pre-edge values.
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tile   <= w_tile_nxt;
            r_num    <= w_num_nxt;
            r_mode   <= w_mode_nxt;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_tile_o <= w_tile_o;
            r_row    <= w_row;
            r_en     <= w_en;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_tile_nxt  = r_tile;
        w_num_nxt   = r_num;
        w_mode_nxt  = r_mode;
        w_tile_inc  = {1'b0, r_tile} + {{TILE_W{1'b0}}, 1'b1};
        case (r_state)
            S_LOAD_W:  w_last_cnt = CNT_W'(LEN_LW - 1);
            S_LOAD_IN: w_last_cnt = CNT_W'(LEN_LI - 1);
            S_WAIT:    w_last_cnt = CNT_W'(LEN_WT - 1);
            S_CAPTURE: w_last_cnt = CNT_W'(LEN_CP - 1);
            S_READOUT: w_last_cnt = CNT_W'(LEN_RO - 1);
            default:   w_last_cnt = '0;
        endcase

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_tile_nxt = '0;
                if (start && !abort) begin
                    w_num_nxt   = num_tiles;
                    w_mode_nxt  = act_mode;
                    w_state_nxt = (num_tiles == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_DONE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                if (r_cnt == w_last_cnt) begin
                    w_cnt_nxt = '0;
                    case (r_state)
                        S_LOAD_W:  w_state_nxt = S_LOAD_IN;
                        S_LOAD_IN: w_state_nxt = S_WAIT;
                        S_WAIT:    w_state_nxt = S_CAPTURE;
                        S_CAPTURE: w_state_nxt = S_READOUT;
                        default: begin
                            if (w_tile_inc < {1'b0, r_num}) begin
                                w_tile_nxt  = w_tile_inc[TILE_W-1:0];
                                w_state_nxt = S_LOAD_W;
                            end else begin
                                w_tile_nxt  = '0;
                                w_state_nxt = S_DONE;
                            end
                        end
                    endcase
                end
            end
        endcase

        // Abort overrides everything outside IDLE; no done pulse is produced.
        if (abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_tile_nxt  = '0;
        end
    end

    // Outputs decoded from the next state so the registered copy lines up with that state.
    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_tile_o = '0;
        w_row    = '0;
        w_en     = '0;
        case (w_state_nxt)
            S_LOAD_W: begin
                w_en[8] = 1'b1;
                w_row   = w_cnt_nxt[ROW_W-1:0];
            end
            S_LOAD_IN: begin
                w_en[7] = 1'b1;
                w_en[6] = 1'b1;
                w_en[5] = 1'b1;
                w_row   = w_cnt_nxt[ROW_W-1:0];
            end
            S_WAIT:    w_en[4] = 1'b1;
            S_CAPTURE: begin
                w_en[4] = 1'b1;
                w_en[3] = 1'b1;
            end
            S_READOUT: begin
                w_en[2] = 1'b1;
                w_en[1] = (w_mode_nxt == 2'b01);
                w_en[0] = (w_mode_nxt == 2'b10);
            end
            S_DONE:  w_done = 1'b1;
            default: w_busy = 1'b0;
        endcase
        if (w_state_nxt != S_IDLE && w_state_nxt != S_DONE) begin
            w_busy   = 1'b1;
            w_tile_o = w_tile_nxt;
        end
    end

    assign busy                  = r_busy;
    assign done                  = r_done;
    assign tile_idx              = r_tile_o;
    assign row_idx               = r_row;
    assign weight_buffer_load_en = r_en[8];
    assign input_buffer_load_en  = r_en[7];
    assign write_weight_en       = r_en[6];
    assign weight_buffer_out_en  = r_en[5];
    assign input_buffer_out_en   = r_en[4];
    assign output_buffer_load_en = r_en[3];
    assign output_buffer_out_en  = r_en[2];
    assign relu_en               = r_en[1];
    assign softmax_en            = r_en[0];

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Bench for accel_seq_ctrl: two geometries (4x4/D2 and 8x8/D1) share one stimulus stream and are
// compared every cycle against a model that derives outputs from the offset into the run.
module tb_accel_seq_ctrl;

    localparam int HA = 4, WA = 4, DA = 2;
    localparam int HB = 8, WB = 8, DB = 1;
    localparam int TA = 4*HA + DA*WA + DA*(HA-1);
    localparam int TB = 4*HB + DB*WB + DB*(HB-1);

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] num_tiles;
    logic [1:0] act_mode;

    logic       busy_a, done_a, wbl_a, wbo_a, ww_a, ibl_a, ibo_a, obl_a, obo_a, relu_a, sm_a;
    logic [7:0] tile_a;
    logic [1:0] row_a;
    logic       busy_b, done_b, wbl_b, wbo_b, ww_b, ibl_b, ibo_b, obl_b, obo_b, relu_b, sm_b;
    logic [7:0] tile_b;
    logic [2:0] row_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    accel_seq_ctrl #(.ARRAY_H(HA), .ARRAY_W(WA), .DSP_DELAY(DA), .TILE_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_tiles(num_tiles), .act_mode(act_mode),
        .busy(busy_a), .done(done_a), .tile_idx(tile_a), .row_idx(row_a),
        .weight_buffer_load_en(wbl_a), .weight_buffer_out_en(wbo_a),
        .write_weight_en(ww_a), .input_buffer_load_en(ibl_a),
        .input_buffer_out_en(ibo_a), .output_buffer_load_en(obl_a),
        .output_buffer_out_en(obo_a), .relu_en(relu_a), .softmax_en(sm_a)
    );

    accel_seq_ctrl #(.ARRAY_H(HB), .ARRAY_W(WB), .DSP_DELAY(DB), .TILE_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_tiles(num_tiles), .act_mode(act_mode),
        .busy(busy_b), .done(done_b), .tile_idx(tile_b), .row_idx(row_b),
        .weight_buffer_load_en(wbl_b), .weight_buffer_out_en(wbo_b),
        .write_weight_en(ww_b), .input_buffer_load_en(ibl_b),
        .input_buffer_out_en(ibo_b), .output_buffer_load_en(obl_b),
        .output_buffer_out_en(obo_b), .relu_en(relu_b), .softmax_en(sm_b)
    );

    wire [31:0] obs_a = {tile_a, 2'b00, row_a, 9'b0, busy_a, done_a, wbl_a, wbo_a, ww_a,
                         ibl_a, ibo_a, obl_a, obo_a, relu_a, sm_a};
    wire [31:0] obs_b = {tile_b, 1'b0, row_b, 9'b0, busy_b, done_b, wbl_b, wbo_b, ww_b,
                         ibl_b, ibo_b, obl_b, obo_b, relu_b, sm_b};

    // Run tracker: k is the cycle offset from t0; the done cycle sits at k == n*T.
    typedef struct {
        bit active;
        int k;
        int n;
        int mode;
    } mdl_t;

    mdl_t ma = '{0, 0, 0, 0};
    mdl_t mb = '{0, 0, 0, 0};

    function automatic mdl_t mdl_step(mdl_t m, int period);
        mdl_t r = m;
        if (rst) begin
            r.active = 0;
        end else if (m.active) begin
            if (abort || m.k >= m.n * period) r.active = 0;
            else                              r.k = m.k + 1;
        end else if (start && !abort) begin
            r.active = 1;
            r.k      = 0;
            r.n      = int'(num_tiles);
            r.mode   = int'(act_mode);
        end
        return r;
    endfunction

    function automatic logic [31:0] mdl_out(mdl_t m, int h, int w, int d);
        int   period = 4*h + d*w + d*(h-1);
        int   p, tile = 0, row = 0;
        logic bsy = 0, dn = 0, wbl = 0, wbo = 0, ww = 0, ibl = 0, ibo = 0;
        logic obl = 0, obo = 0, relu = 0, sm = 0;
        if (m.active) begin
            if (m.k == m.n * period) begin
                dn = 1;
            end else begin
                bsy  = 1;
                tile = m.k / period;
                p    = m.k % period;
                if (p < h) begin
                    wbl = 1; row = p;
                end else if (p < 2*h) begin
                    ibl = 1; ww = 1; wbo = 1; row = p - h;
                end else if (p < 2*h + d*w) begin
                    ibo = 1;
                end else if (p < 2*h + d*w + d*(h-1) + h) begin
                    ibo = 1; obl = 1;
                end else begin
                    obo = 1; relu = (m.mode == 1); sm = (m.mode == 2);
                end
            end
        end
        return {8'(tile), 4'(row), 9'b0, bsy, dn, wbl, wbo, ww, ibl, ibo, obl, obo, relu, sm};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ma = mdl_step(ma, TA);
        mb = mdl_step(mb, TB);
        cyc++;
        @(negedge clk);
        check("dut_a", obs_a, mdl_out(ma, HA, WA, DA));
        check("dut_b", obs_b, mdl_out(mb, HB, WB, DB));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start(input int n, input int mode);
        start     = 1'b1;
        num_tiles = 8'(n);
        act_mode  = 2'(mode);
        step();
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_tiles = 8'd0; act_mode = 2'd0;
        step();
        start = 1'b1; num_tiles = 8'd2;
        step();
        rst = 1'b0; start = 1'b0;
        run(2);

        // single tile, no activation
        pulse_start(1, 0);
        run(TB + 3);

        // three back-to-back tiles, softmax
        pulse_start(3, 2);
        run(3*TB + 3);

        // abort at t0+12, then a clean run
        pulse_start(2, 1);
        run(12);
        abort = 1'b1;
        step();
        abort = 1'b0;
        run(4);
        pulse_start(1, 1);
        run(TB + 3);

        // start pulses while busy are ignored
        pulse_start(3, 0);
        run(5);
        pulse_start(1, 2);
        run(34);
        pulse_start(2, 1);
        run(3*TB);

        // abort and start together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; num_tiles = 8'd2;
        step();
        start = 1'b0; abort = 1'b0;
        run(3);

        // zero tiles, then reset in the middle of a run
        pulse_start(0, 1);
        run(3);
        pulse_start(2, 0);
        run(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(3);

        // mode 11 behaves as none
        pulse_start(1, 3);
        run(TB + 3);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int len;
            pulse_start($urandom_range(0, 3), $urandom_range(0, 3));
            len = $urandom_range(5, 200);
            for (int j = 0; j < len; j++) begin
                start     = ($urandom_range(0, 15) == 0);
                abort     = ($urandom_range(0, 79) == 0);
                rst       = ($urandom_range(0, 299) == 0);
                num_tiles = 8'($urandom_range(0, 3));
                act_mode  = 2'($urandom_range(0, 3));
                step();
            end
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            run(3*TB + 2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
